// File: rtl/pbpix_fifo.sv
// First-word-fall-through pixel FIFO with optional zero-beat skipping; 1-cycle fill latency, no bypass.
// Backpressure: src_ack drops when full (zero beats still acked when ZSKIP=1); dst_rdy while non-empty.
module pbpix_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int ZSKIP = 0,
  parameter int AF_TH = DEPTH - 1
) (
  input  logic                       i_clk,
  input  logic                       i_rstn,
  input  logic                       i_clr,
  input  logic                       src_rdy,
  output logic                       src_ack,
  input  logic                       src_zero,
  input  logic [DW-1:0]              src_data,
  output logic                       dst_rdy,
  input  logic                       dst_ack,
  output logic                       dst_zero,
  output logic [DW-1:0]              dst_data,
  output logic [$clog2(DEPTH+1)-1:0] o_cnt,
  output logic                       o_afull,
  output logic [15:0]                o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [15:0]   drop_q;

  logic full;
  logic drop_beat;
  logic push;
  logic pop;

  assign full      = (cnt_q == CW'(DEPTH));
  assign drop_beat = (ZSKIP != 0) && src_zero;
  assign src_ack   = !full || drop_beat;
  // Acceptance uses the pre-pop count, so a full FIFO never passes a beat through.
  assign push      = src_rdy && src_ack && !drop_beat;
  assign dst_rdy   = (cnt_q != '0);
  assign pop       = dst_rdy && dst_ack;

  assign {dst_zero, dst_data} = mem[rd_ptr];
  assign o_cnt   = cnt_q;
  assign o_afull = (cnt_q >= CW'(AF_TH));
  assign o_drop  = drop_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn || i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (src_rdy && drop_beat && (drop_q != 16'hFFFF)) drop_q <= drop_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {src_zero, src_data};
  end

endmodule

// File: tb/tb_pbpix_fifo.sv
// Randomised and directed bench for pbpix_fifo, one instance per ZSKIP mode sharing one stimulus stream.
module tb_pbpix_fifo;
  localparam int DW = 8, DEPTH = 4, AF_TH = 3, CW = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rstn, clr, src_rdy, src_zero, dst_ack;
  logic [DW-1:0] src_data;

  logic ack0, rdy0, z0, af0, ack1, rdy1, z1, af1;
  logic [DW-1:0] d0, d1;
  logic [CW-1:0] cnt0, cnt1;
  logic [15:0] drop0, drop1;

  int checks = 0, passed = 0;
  bit mon_en = 1'b0;

  logic [DW:0] mq0[$];
  logic [DW:0] mq1[$];
  int drop_m1 = 0;

  always #5 clk = ~clk;

  pbpix_fifo #(.DW(DW), .DEPTH(DEPTH), .ZSKIP(0), .AF_TH(AF_TH)) dut0 (
    .i_clk(clk), .i_rstn(rstn), .i_clr(clr),
    .src_rdy(src_rdy), .src_ack(ack0), .src_zero(src_zero), .src_data(src_data),
    .dst_rdy(rdy0), .dst_ack(dst_ack), .dst_zero(z0), .dst_data(d0),
    .o_cnt(cnt0), .o_afull(af0), .o_drop(drop0));

  pbpix_fifo #(.DW(DW), .DEPTH(DEPTH), .ZSKIP(1), .AF_TH(AF_TH)) dut1 (
    .i_clk(clk), .i_rstn(rstn), .i_clr(clr),
    .src_rdy(src_rdy), .src_ack(ack1), .src_zero(src_zero), .src_data(src_data),
    .dst_rdy(rdy1), .dst_ack(dst_ack), .dst_zero(z1), .dst_data(d1),
    .o_cnt(cnt1), .o_afull(af1), .o_drop(drop1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: queues hold the stored beats; acceptance from queue size.
  always @(posedge clk) begin
    bit pop0, push0, pop1, acc1;
    if (!rstn || clr) begin
      mq0.delete();
      mq1.delete();
      drop_m1 = 0;
    end else begin
      pop0  = dst_ack && (mq0.size() > 0);
      push0 = src_rdy && (mq0.size() < DEPTH);
      pop1  = dst_ack && (mq1.size() > 0);
      acc1  = src_rdy && ((mq1.size() < DEPTH) || src_zero);
      if (pop0) void'(mq0.pop_front());
      if (pop1) void'(mq1.pop_front());
      if (push0) mq0.push_back({src_zero, src_data});
      if (acc1 && src_zero) begin
        if (drop_m1 < 'hFFFF) drop_m1++;
      end else if (acc1) begin
        mq1.push_back({src_zero, src_data});
      end
    end
  end

  // Monitor: status against the model, and the presented head against the oldest stored beat.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("cnt0", cnt0, mq0.size());
      chk("rdy0", rdy0, mq0.size() != 0);
      chk("ack0", ack0, mq0.size() < DEPTH);
      chk("afull0", af0, mq0.size() >= AF_TH);
      chk("drop0", drop0, 0);
      if (rdy0 && mq0.size() > 0) chk("head0", {z0, d0}, mq0[0]);
      chk("cnt1", cnt1, mq1.size());
      chk("rdy1", rdy1, mq1.size() != 0);
      chk("ack1", ack1, (mq1.size() < DEPTH) || src_zero);
      chk("afull1", af1, mq1.size() >= AF_TH);
      chk("drop1", drop1, drop_m1);
      if (rdy1 && mq1.size() > 0) chk("head1", {z1, d1}, mq1[0]);
    end
  end

  task automatic cyc(input bit r, input bit z, input logic [DW-1:0] d, input bit a,
                     input bit c = 1'b0, input bit rn = 1'b1);
    src_rdy = r; src_zero = z; src_data = d; dst_ack = a; clr = c; rstn = rn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; clr = 1'b0; src_rdy = 1'b0; src_zero = 1'b0; src_data = '0; dst_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_cnt", cnt0, 0);
    chk("rst_rdy", rdy0, 0);
    chk("rst_ack", ack0, 1);
    chk("rst_afull", af0, 0);
    chk("rst_drop", drop1, 0);

    // Fill to full, then pop-with-push-attempt while full, then drain in order.
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, DW'(8'h11 * (i + 1)), 0);
      if (i == 2) chk("afull_at3", af0, 1);
    end
    chk("full_cnt", cnt0, 4);
    chk("full_ack", ack0, 0);
    cyc(1, 0, 8'h55, 1);
    chk("nopass_cnt", cnt0, 3);
    cyc(1, 0, 8'h55, 0);
    chk("refill_cnt", cnt0, 4);
    repeat (5) cyc(0, 0, 8'h00, 1);
    chk("drained", rdy0, 0);

    // One entry resident, streaming push+pop; pointers wrap repeatedly.
    cyc(1, 0, 8'hA0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, DW'(8'hB0 + i), 1);
      chk("stream_cnt", cnt0, 1);
    end
    cyc(0, 0, 8'h00, 1);

    // Zero-skip pattern 0,1,1,0,1.
    cyc(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, (i == 1 || i == 2 || i == 4), DW'(i + 1), 0);
    chk("zs_cnt", cnt1, 2);
    chk("zs_drop", drop1, 3);
    cyc(1, 0, 8'h66, 0);
    cyc(1, 0, 8'h77, 0);
    chk("zs_full", cnt1, 4);
    src_zero = 1'b1; src_rdy = 1'b1; #1;
    chk("zs_ack_full", ack1, 1);
    chk("nz_ack_full", ack0, 0);
    cyc(1, 1, 8'h00, 0);
    chk("zs_drop_full", drop1, 4);

    // Drop counter saturation.
    cyc(0, 0, 8'h00, 0, 1);
    force dut1.drop_q = 16'hFFFE;
    drop_m1 = 'hFFFE;
    cyc(0, 0, 8'h00, 0);
    release dut1.drop_q;
    for (int i = 0; i < 3; i++) cyc(1, 1, 8'h00, 0);
    chk("drop_sat", drop1, 16'hFFFF);

    // Clear and reset, each with a push in the same cycle.
    for (int i = 0; i < 3; i++) cyc(1, 0, DW'(8'hC0 + i), 0);
    cyc(1, 0, 8'hCF, 0, 1);
    chk("clr_cnt", cnt0, 0);
    chk("clr_rdy", rdy0, 0);
    chk("clr_drop", drop1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, DW'(8'hD0 + i), 0);
    cyc(1, 1, 8'h00, 0);
    cyc(1, 0, 8'hDF, 1, 0, 0);
    chk("rstn_cnt", cnt1, 0);
    chk("rstn_rdy", rdy1, 0);
    chk("rstn_drop", drop1, 0);

    // Random traffic with occasional flushes and resets.
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, DW'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 99) != 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/pbpix_fifo.md
PBPIX_FIFO -- requirements
Module: pbpix_fifo

Interface
REQ-001 Parameter DW, default 8: payload width in bits, range 1..64.
REQ-002 Parameter DEPTH, default 4: storage entries, power of two, range 2..256.
REQ-003 Parameter ZSKIP, default 0: 0 = zero-flagged beats stored; 1 = zero-flagged beats dropped and counted.
REQ-004 Parameter AF_TH, default DEPTH-1: almost-full threshold, range 1..DEPTH.
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_rstn  in  1  synchronous active-low reset, sampled on the i_clk rising edge.
REQ-007 i_clr  in  1  synchronous flush, active-high.
REQ-008 src_rdy  in  1  producer beat valid.
REQ-009 src_ack  out  1  beat accepted; a transfer occurs when src_rdy && src_ack.
REQ-010 src_zero  in  1  beat is an all-zero pixel.
REQ-011 src_data  in  DW  payload.
REQ-012 dst_rdy  out  1  head entry valid.
REQ-013 dst_ack  in  1  consumer takes the head; a transfer occurs when dst_rdy && dst_ack.
REQ-014 dst_zero  out  1  zero flag of the head entry.
REQ-015 dst_data  out  DW  payload of the head entry.
REQ-016 o_cnt  out  $clog2(DEPTH+1)  occupancy.
REQ-017 o_afull  out  1  asserted when o_cnt >= AF_TH.
REQ-018 o_drop  out  16  number of dropped zero beats, saturating.

Function
REQ-019 Storage SHALL be a circular buffer of DEPTH entries, each {zero, data}, with write pointer, read pointer and counter.
REQ-020 src_ack SHALL equal !full when ZSKIP=0, and !full || src_zero when ZSKIP=1; it SHALL be combinational from state and src_zero only.
REQ-021 A full FIFO SHALL NOT accept a non-dropped beat, even when a pop occurs in the same cycle (no pass-through).
REQ-022 dst_rdy SHALL equal (o_cnt != 0); dst_data and dst_zero SHALL present the head entry in first-word-fall-through fashion.
REQ-023 A beat accepted in cycle N SHALL be visible at dst in cycle N+1 when the FIFO was empty; latency SHALL be 1 cycle with no bypass.
REQ-024 Push without pop SHALL increment o_cnt; pop without push SHALL decrement it; simultaneous push and pop SHALL leave it unchanged.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 When ZSKIP=1, an accepted beat with src_zero=1 SHALL NOT be written, and SHALL increment o_drop, saturating at 16'hFFFF.
REQ-027 When ZSKIP=0, o_drop SHALL remain 0.
REQ-028 dst_data SHALL hold its value while dst_rdy=1 and dst_ack=0.
REQ-029 i_clr=1 SHALL empty the FIFO and zero o_drop on the next edge, and SHALL take priority over a push or pop in the same cycle; src_ack and dst_rdy follow REQ-020 and REQ-022 during that cycle.
REQ-030 dst_data and dst_zero SHALL be don't-care while dst_rdy=0, and the bench SHALL NOT check them.

Reset
REQ-031 When i_rstn=0 at a rising edge, pointers, o_cnt and o_drop SHALL become 0, so that dst_rdy=0, o_afull=0 and src_ack=1 after that edge.
REQ-032 Reset SHALL override i_clr and any handshake in the same cycle; a reset mid-stream SHALL discard all stored entries.
REQ-033 Storage contents SHALL need no reset.

Verification (DW=8, DEPTH=4, AF_TH=3 unless stated)
REQ-034 Push 0x11,0x22,0x33,0x44 with dst_ack=0 -> o_cnt=4, src_ack=0, o_afull=1 after the third push; drain -> outputs in order 11,22,33,44.
REQ-035 With FIFO full, assert src_rdy and dst_ack in the same cycle -> pop occurs, no push, o_cnt=3; next cycle the push is accepted.
REQ-036 With one entry stored, push and pop continuously for 10 cycles -> o_cnt stays 1, data stays in order, and pointers wrap at least twice.
REQ-037 ZSKIP=1: send 5 beats with zero flags 0,1,1,0,1 -> 2 entries stored, o_drop=3, and src_ack=1 on zero beats even when the FIFO is full.
REQ-038 ZSKIP=1: force o_drop to 16'hFFFE, send 3 zero beats -> o_drop=16'hFFFF and stays there.
REQ-039 With 3 entries stored, pulse i_clr with a push in the same cycle -> o_cnt=0, dst_rdy=0 next cycle; repeat with i_rstn=0 -> same result, and o_drop=0.
